// File: rtl/stack_ctrl.sv
// Stack access sequencer: owns the stack pointer and turns push/pop requests
// into single-word data-memory accesses with a ready handshake.
module stack_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned BASE_ADDR = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         op,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         mem_ready,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_wr,
  output logic                         mem_rd,
  output logic [DATA_W-1:0]            rdata,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         full,
  output logic                         empty,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned SP_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                full_c, empty_c;
  logic [ADDR_W-1:0]   top_addr_c;

  assign full_c     = (sp_q == SP_W'(DEPTH));
  assign empty_c    = (sp_q == '0);
  assign top_addr_c = ADDR_W'(BASE_ADDR) + ADDR_W'(sp_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (!op) begin
            if (full_c) begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end else begin
              wdata_d = wdata;
              addr_d  = top_addr_c;
              wr_d    = 1'b1;
              state_d = ST_WRITE;
            end
          end else begin
            if (empty_c) begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end else begin
              addr_d  = top_addr_c - ADDR_W'(1);
              rd_d    = 1'b1;
              state_d = ST_READ;
            end
          end
        end
      end

      ST_WRITE: begin
        if (mem_ready) begin
          sp_d    = sp_q + SP_W'(1);
          wr_d    = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          sp_d    = sp_q - SP_W'(1);
          rd_d    = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset aborts any access in flight; sp is left at its reset value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sp_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = wr_q;
  assign mem_rd    = rd_q;
  assign rdata     = rdata_q;
  assign sp        = sp_q;
  assign full      = full_c;
  assign empty     = empty_c;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based stack model.
module tb_stack_ctrl;

  localparam int unsigned MD   = 4;
  localparam int unsigned BASE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        op = 1'b0;
  logic [31:0] wdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic        mem_wr, mem_rd, full, empty, busy, done, err;
  logic [2:0]  sp;

  logic [31:0] tbmem [64];
  logic [31:0] junk = 32'hA5A5_5A5A;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  // Behavioural model: a queue is the stack, one access may be outstanding
  logic [31:0] stk[$];
  bit          m_busy = 0, m_pop = 0, m_done = 0, m_err = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  stack_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(MD), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd), .rdata(rdata),
    .sp(sp), .full(full), .empty(empty), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_rd ? tbmem[mem_addr[5:0]] : junk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_busy = 0; m_pop = 0; m_done = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic model_step(input logic r, input logic o, input logic [31:0] d, input logic rdy);
    m_done = 0;
    m_err  = 0;
    if (!m_busy) begin
      if (r) begin
        if (!o) begin
          if (stk.size() == MD) begin
            m_done = 1; m_err = 1;
          end else begin
            m_busy = 1; m_pop = 0; m_wdata = d;
            m_addr = BASE + 32'(stk.size());
          end
        end else begin
          if (stk.size() == 0) begin
            m_done = 1; m_err = 1;
          end else begin
            m_busy = 1; m_pop = 1;
            m_addr = BASE + 32'(stk.size()) - 1;
          end
        end
      end
    end else if (rdy) begin
      m_busy = 0;
      m_done = 1;
      if (m_pop) m_rdata = stk.pop_back();
      else       stk.push_back(m_wdata);
    end
  endtask

  // Memory, model update and per-cycle compare
  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
    end else begin
      if (mem_wr && mem_ready) tbmem[mem_addr[5:0]] = mem_wdata;
      model_step(req, op, wdata, mem_ready);
    end
    #1;
    if (done) done_cnt++;
    if (rst) begin
      check("sp",        64'(sp),        64'(stk.size()));
      check("full",      64'(full),      64'(stk.size() == MD));
      check("empty",     64'(empty),     64'(stk.size() == 0));
      check("busy",      64'(busy),      64'(m_busy));
      check("done",      64'(done),      64'(m_done));
      check("err",       64'(err),       64'(m_err));
      check("mem_wr",    64'(mem_wr),    64'(m_busy && !m_pop));
      check("mem_rd",    64'(mem_rd),    64'(m_busy && m_pop));
      check("mem_addr",  64'(mem_addr),  64'(m_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      check("rdata",     64'(rdata),     64'(m_rdata));
    end
  end

  // Successful op with w wait cycles; ends in the done cycle
  task automatic do_op(input logic o, input logic [31:0] d, input int w, input logic [31:0] exp_addr);
    mem_ready = 0; req = 1; op = o; wdata = d;
    @(negedge clk);
    req = 0;
    for (int i = 0; i <= w; i++) begin
      check("strobe", 64'(o ? mem_rd : mem_wr), 64'd1);
      check("strobe_addr", 64'(mem_addr), 64'(exp_addr));
      if (i == w) mem_ready = 1;
      @(negedge clk);
    end
    mem_ready = 0;
    check("op_done", 64'(done), 64'd1);
    check("op_err",  64'(err),  64'd0);
  endtask

  task automatic do_reject(input logic o);
    req = 1; op = o;
    @(negedge clk);
    req = 0;
    check("rej_done", 64'(done), 64'd1);
    check("rej_err",  64'(err),  64'd1);
    check("rej_wr",   64'(mem_wr), 64'd0);
    check("rej_rd",   64'(mem_rd), 64'd0);
    check("rej_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int dc;
    for (int i = 0; i < 64; i++) tbmem[i] = 32'(i) * 32'h0101_0101;
    repeat (3) @(negedge clk);
    check("rst_sp",    64'(sp),    64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full",  64'(full),  64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_wr",    64'(mem_wr), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_addr",  64'(mem_addr), 64'd0);
    rst = 1;
    @(negedge clk);

    // Single push, then pop it back
    do_op(0, 32'hDEADBEEF, 0, 32'd8);
    check("push1_sp", 64'(sp), 64'd1);
    check("push1_empty", 64'(empty), 64'd0);
    do_op(1, '0, 0, 32'd8);
    check("pop1_rdata", 64'(rdata), 64'hDEADBEEF);

    // Fill, then overflow
    for (int i = 0; i < 4; i++) do_op(0, 32'h11 * 32'(i + 1), i % 2, 32'(8 + i));
    check("fill_sp", 64'(sp), 64'd4);
    check("fill_full", 64'(full), 64'd1);
    do_reject(0);
    check("ovf_sp", 64'(sp), 64'd4);

    // Pops with wait states, LIFO order
    do_op(1, '0, 2, 32'd11);
    check("pop44", 64'(rdata), 64'h44);
    check("pop44_sp", 64'(sp), 64'd3);
    for (int i = 2; i >= 0; i--) begin
      do_op(1, '0, i, 32'(8 + i));
      check("pop_data", 64'(rdata), 64'(32'h11 * 32'(i + 1)));
    end

    // Underflow
    do_reject(1);
    check("udf_sp", 64'(sp), 64'd0);
    check("udf_rdata", 64'(rdata), 64'h11);

    // Request while busy is ignored
    dc = done_cnt;
    mem_ready = 0; req = 1; op = 0; wdata = 32'h55;
    @(negedge clk);
    op = 1;
    repeat (2) @(negedge clk);
    req = 0; mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    repeat (3) @(negedge clk);
    check("busy_done_cnt", 64'(done_cnt - dc), 64'd1);
    check("busy_sp", 64'(sp), 64'd1);

    // Reset in the middle of a write
    req = 1; op = 0; wdata = 32'h66;
    @(negedge clk);
    req = 0;
    check("mid_wr", 64'(mem_wr), 64'd1);
    #2 rst = 0;
    #1;
    check("mid_rst_wr", 64'(mem_wr), 64'd0);
    check("mid_rst_sp", 64'(sp), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    do_op(0, 32'h77, 0, 32'd8);
    check("post_rst_sp", 64'(sp), 64'd1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      junk      = $urandom;
      req       = ($urandom_range(0, 2) == 0);
      op        = 1'($urandom_range(0, 1));
      wdata     = $urandom;
      mem_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 0;
        @(negedge clk);
        rst = 1;
      end
    end
    req = 0; mem_ready = 1;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
